// File: rtl/npu_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : npu_mem_pkg
// Description : Shared types and constants for the NPU memory responder.
// Revision    : 1.0 - initial release
// ============================================================================
package npu_mem_pkg;

    localparam int ADDR_W_DEF = 14;
    localparam int DATA_W_DEF = 16;

    localparam logic OP_LOAD   = 1'b0;
    localparam logic OP_UNLOAD = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_UNLOAD = 2'd2,
        ST_FINISH = 2'd3
    } host_state_t;

endpackage
`default_nettype wire

// File: rtl/npu_mem_array.sv
`default_nettype none
// ============================================================================
// Module      : npu_mem_array
// Description : Shared word array, combinational reads, prioritized writes
//               (dest > src1 > src2 > host) and engine write-conflict detect.
// Revision    : 1.0 - initial release
// ============================================================================
module npu_mem_array
    import npu_mem_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] src1_address,
    output logic [DATA_W-1:0] src1_readdata,
    input  logic [DATA_W-1:0] src1_writedata,
    input  logic              src1_write_en,
    input  logic [ADDR_W-1:0] src2_address,
    output logic [DATA_W-1:0] src2_readdata,
    input  logic [DATA_W-1:0] src2_writedata,
    input  logic              src2_write_en,
    input  logic [ADDR_W-1:0] dest_address,
    output logic [DATA_W-1:0] dest_readdata,
    input  logic [DATA_W-1:0] dest_writedata,
    input  logic              dest_write_en,
    input  logic [ADDR_W-1:0] host_raddr,
    output logic [DATA_W-1:0] host_rdata,
    input  logic [ADDR_W-1:0] host_waddr,
    input  logic [DATA_W-1:0] host_wdata,
    input  logic              host_we,
    output logic              wr_conflict
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic              r_conflict;
    logic              w_conflict;

    assign src1_readdata = r_mem[src1_address];
    assign src2_readdata = r_mem[src2_address];
    assign dest_readdata = r_mem[dest_address];
    assign host_rdata    = r_mem[host_raddr];

    // Later assignments override earlier ones, giving dest the highest priority.
    always_ff @(posedge clk) begin
        if (host_we)       r_mem[host_waddr]   <= host_wdata;
        if (src2_write_en) r_mem[src2_address] <= src2_writedata;
        if (src1_write_en) r_mem[src1_address] <= src1_writedata;
        if (dest_write_en) r_mem[dest_address] <= dest_writedata;
    end

    assign w_conflict = (dest_write_en && src1_write_en && (dest_address == src1_address)) ||
                        (dest_write_en && src2_write_en && (dest_address == src2_address)) ||
                        (src1_write_en && src2_write_en && (src1_address == src2_address));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_conflict <= 1'b0;
        else       r_conflict <= w_conflict;
    end

    assign wr_conflict = r_conflict;

endmodule
`default_nettype wire

// File: rtl/npu_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : npu_mem_responder
// Description : Memory-side responder for the convolution engine with a host
//               LOAD/UNLOAD streaming path active while the engine is idle.
// Revision    : 1.0 - initial release
// ============================================================================
module npu_mem_responder
    import npu_mem_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              eng_busy,
    input  logic [ADDR_W-1:0] src1_address,
    output logic [DATA_W-1:0] src1_readdata,
    input  logic [DATA_W-1:0] src1_writedata,
    input  logic              src1_write_en,
    input  logic [ADDR_W-1:0] src2_address,
    output logic [DATA_W-1:0] src2_readdata,
    input  logic [DATA_W-1:0] src2_writedata,
    input  logic              src2_write_en,
    input  logic [ADDR_W-1:0] dest_address,
    output logic [DATA_W-1:0] dest_readdata,
    input  logic [DATA_W-1:0] dest_writedata,
    input  logic              dest_write_en,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_op,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [ADDR_W-1:0] cmd_len,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [DATA_W-1:0] ld_data,
    output logic              ul_valid,
    input  logic              ul_ready,
    output logic [DATA_W-1:0] ul_data,
    output logic              ul_last,
    output logic              host_done,
    output logic              wr_conflict
);

    host_state_t       r_state, w_state_nxt;
    logic [ADDR_W-1:0] r_ptr, w_ptr_nxt;
    logic [ADDR_W-1:0] r_rem, w_rem_nxt;
    logic              r_ul_valid, w_ul_valid_nxt;
    logic              r_ul_last, w_ul_last_nxt;
    logic [DATA_W-1:0] r_ul_data, w_ul_data_nxt;
    logic              w_host_we;
    logic [ADDR_W-1:0] w_host_raddr;
    logic [DATA_W-1:0] w_host_rdata;
    logic              w_ul_take;

    npu_mem_array #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_array (
        .clk            (clk),
        .reset          (reset),
        .src1_address   (src1_address),
        .src1_readdata  (src1_readdata),
        .src1_writedata (src1_writedata),
        .src1_write_en  (src1_write_en),
        .src2_address   (src2_address),
        .src2_readdata  (src2_readdata),
        .src2_writedata (src2_writedata),
        .src2_write_en  (src2_write_en),
        .dest_address   (dest_address),
        .dest_readdata  (dest_readdata),
        .dest_writedata (dest_writedata),
        .dest_write_en  (dest_write_en),
        .host_raddr     (w_host_raddr),
        .host_rdata     (w_host_rdata),
        .host_waddr     (r_ptr),
        .host_wdata     (ld_data),
        .host_we        (w_host_we),
        .wr_conflict    (wr_conflict)
    );

    assign cmd_ready = (r_state == ST_IDLE) && !eng_busy && !reset;
    assign ld_ready  = (r_state == ST_LOAD) && !eng_busy;
    assign host_done = (r_state == ST_FINISH);
    assign ul_valid  = r_ul_valid;
    assign ul_last   = r_ul_last;
    assign ul_data   = r_ul_data;
    assign w_ul_take = r_ul_valid && ul_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_ptr      <= '0;
            r_rem      <= '0;
            r_ul_valid <= 1'b0;
            r_ul_last  <= 1'b0;
            r_ul_data  <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_ptr      <= w_ptr_nxt;
            r_rem      <= w_rem_nxt;
            r_ul_valid <= w_ul_valid_nxt;
            r_ul_last  <= w_ul_last_nxt;
            r_ul_data  <= w_ul_data_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_ptr_nxt      = r_ptr;
        w_rem_nxt      = r_rem;
        w_ul_valid_nxt = r_ul_valid;
        w_ul_last_nxt  = r_ul_last;
        w_ul_data_nxt  = r_ul_data;
        w_host_we      = 1'b0;
        w_host_raddr   = r_ptr;

        case (r_state)
            ST_IDLE: begin
                // First unload word is fetched at accept so it is valid next cycle.
                w_host_raddr = cmd_addr;
                if (cmd_valid && cmd_ready) begin
                    w_ptr_nxt = cmd_addr;
                    w_rem_nxt = cmd_len;
                    if (cmd_len == '0) begin
                        w_state_nxt = ST_FINISH;
                    end else if (cmd_op == OP_LOAD) begin
                        w_state_nxt = ST_LOAD;
                    end else begin
                        w_state_nxt    = ST_UNLOAD;
                        w_ul_data_nxt  = w_host_rdata;
                        w_ul_valid_nxt = 1'b1;
                        w_ul_last_nxt  = (cmd_len == ADDR_W'(1));
                        w_ptr_nxt      = cmd_addr + ADDR_W'(1);
                        w_rem_nxt      = cmd_len - ADDR_W'(1);
                    end
                end
            end
            ST_LOAD: begin
                if (ld_valid && ld_ready) begin
                    w_host_we = 1'b1;
                    w_ptr_nxt = r_ptr + ADDR_W'(1);
                    w_rem_nxt = r_rem - ADDR_W'(1);
                    if (r_rem == ADDR_W'(1)) w_state_nxt = ST_FINISH;
                end
            end
            ST_UNLOAD: begin
                if (w_ul_take && r_ul_last) begin
                    w_state_nxt    = ST_FINISH;
                    w_ul_valid_nxt = 1'b0;
                    w_ul_last_nxt  = 1'b0;
                end else if (!eng_busy && (!r_ul_valid || ul_ready) && (r_rem != '0)) begin
                    w_ul_data_nxt  = w_host_rdata;
                    w_ul_valid_nxt = 1'b1;
                    w_ul_last_nxt  = (r_rem == ADDR_W'(1));
                    w_ptr_nxt      = r_ptr + ADDR_W'(1);
                    w_rem_nxt      = r_rem - ADDR_W'(1);
                end else if (w_ul_take) begin
                    w_ul_valid_nxt = 1'b0;
                end
            end
            ST_FINISH: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_npu_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_npu_mem_responder
// Description : Directed self-checking bench for npu_mem_responder.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_npu_mem_responder;

    localparam int ADDR_W = 14;
    localparam int DATA_W = 16;

    logic              clk = 1'b0;
    logic              reset;
    logic              eng_busy;
    logic [ADDR_W-1:0] src1_address, src2_address, dest_address;
    logic [DATA_W-1:0] src1_readdata, src2_readdata, dest_readdata;
    logic [DATA_W-1:0] src1_writedata, src2_writedata, dest_writedata;
    logic              src1_write_en, src2_write_en, dest_write_en;
    logic              cmd_valid, cmd_ready, cmd_op;
    logic [ADDR_W-1:0] cmd_addr, cmd_len;
    logic              ld_valid, ld_ready;
    logic [DATA_W-1:0] ld_data;
    logic              ul_valid, ul_ready, ul_last;
    logic [DATA_W-1:0] ul_data;
    logic              host_done, wr_conflict;

    int n_vec = 0;
    int n_err = 0;

    npu_mem_responder #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .reset(reset), .eng_busy(eng_busy),
        .src1_address(src1_address), .src1_readdata(src1_readdata),
        .src1_writedata(src1_writedata), .src1_write_en(src1_write_en),
        .src2_address(src2_address), .src2_readdata(src2_readdata),
        .src2_writedata(src2_writedata), .src2_write_en(src2_write_en),
        .dest_address(dest_address), .dest_readdata(dest_readdata),
        .dest_writedata(dest_writedata), .dest_write_en(dest_write_en),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_data(ld_data),
        .ul_valid(ul_valid), .ul_ready(ul_ready), .ul_data(ul_data), .ul_last(ul_last),
        .host_done(host_done), .wr_conflict(wr_conflict)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    logic [DATA_W-1:0] ld_vec [4];

    initial begin
        ld_vec = '{16'h3C00, 16'h4000, 16'h4200, 16'h4400};
        reset = 1'b1; eng_busy = 1'b0;
        src1_address = '0; src2_address = '0; dest_address = '0;
        src1_writedata = '0; src2_writedata = '0; dest_writedata = '0;
        src1_write_en = 1'b0; src2_write_en = 1'b0; dest_write_en = 1'b0;
        cmd_valid = 1'b0; cmd_op = 1'b0; cmd_addr = '0; cmd_len = '0;
        ld_valid = 1'b0; ld_data = '0; ul_ready = 1'b0;

        // Reset state
        tick(); tick();
        chk("rst_cmd_ready", 32'(cmd_ready), 0);
        chk("rst_ld_ready", 32'(ld_ready), 0);
        chk("rst_ul_valid", 32'(ul_valid), 0);
        chk("rst_ul_last", 32'(ul_last), 0);
        chk("rst_ul_data", 32'(ul_data), 0);
        chk("rst_host_done", 32'(host_done), 0);
        chk("rst_wr_conflict", 32'(wr_conflict), 0);
        reset = 1'b0;

        // LOAD 0x0010 len 4 with ld_valid toggling
        cmd_valid = 1'b1; cmd_op = 1'b0; cmd_addr = 14'h0010; cmd_len = 14'd4;
        #1 chk("ld_cmd_ready", 32'(cmd_ready), 1);
        tick();
        cmd_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            ld_valid = 1'b0;
            tick();
            ld_valid = 1'b1; ld_data = ld_vec[i];
            #1 chk("ld_ready", 32'(ld_ready), 1);
            chk("ld_no_done", 32'(host_done), 0);
            tick();
        end
        ld_valid = 1'b0;
        #1 chk("ld_host_done", 32'(host_done), 1);
        tick();
        chk("ld_host_done_clr", 32'(host_done), 0);
        for (int i = 0; i < 4; i++) begin
            src1_address = 14'h0010 + 14'(i);
            #1 chk("ld_readback", 32'(src1_readdata), 32'(ld_vec[i]));
        end

        // UNLOAD 0x0010 len 3 with backpressure on the first word
        cmd_valid = 1'b1; cmd_op = 1'b1; cmd_addr = 14'h0010; cmd_len = 14'd3; ul_ready = 1'b0;
        tick();
        cmd_valid = 1'b0;
        chk("ul_first_valid", 32'(ul_valid), 1);
        chk("ul_first_data", 32'(ul_data), 32'h3C00);
        tick();
        chk("ul_hold1_data", 32'(ul_data), 32'h3C00);
        tick();
        chk("ul_hold2_valid", 32'(ul_valid), 1);
        chk("ul_hold2_data", 32'(ul_data), 32'h3C00);
        chk("ul_hold2_last", 32'(ul_last), 0);
        ul_ready = 1'b1;
        tick();
        chk("ul_w2_data", 32'(ul_data), 32'h4000);
        chk("ul_w2_last", 32'(ul_last), 0);
        tick();
        chk("ul_w3_data", 32'(ul_data), 32'h4200);
        chk("ul_w3_last", 32'(ul_last), 1);
        chk("ul_w3_no_done", 32'(host_done), 0);
        tick();
        chk("ul_host_done", 32'(host_done), 1);
        chk("ul_valid_clr", 32'(ul_valid), 0);
        chk("ul_last_clr", 32'(ul_last), 0);
        ul_ready = 1'b0;
        tick();

        // Engine write conflict at 0x0020: dest wins
        src1_address = 14'h0020; src1_writedata = 16'h1111; src1_write_en = 1'b1;
        dest_address = 14'h0020; dest_writedata = 16'h2222; dest_write_en = 1'b1;
        #1 chk("conf_pre", 32'(wr_conflict), 0);
        tick();
        src1_write_en = 1'b0; dest_write_en = 1'b0; src2_address = 14'h0020;
        #1 chk("conf_pulse", 32'(wr_conflict), 1);
        chk("conf_data", 32'(src2_readdata), 32'h2222);
        tick();
        chk("conf_pulse_end", 32'(wr_conflict), 0);

        // Different addresses both commit, no pulse
        src1_address = 14'h0021; src1_writedata = 16'hAAAA; src1_write_en = 1'b1;
        dest_address = 14'h0022; dest_writedata = 16'hBBBB; dest_write_en = 1'b1;
        tick();
        src1_write_en = 1'b0; dest_write_en = 1'b0;
        #1 chk("nconf_pulse", 32'(wr_conflict), 0);
        chk("nconf_src1", 32'(src1_readdata), 32'hAAAA);
        chk("nconf_dest", 32'(dest_readdata), 32'hBBBB);

        // Read during write returns the old value
        dest_writedata = 16'hCCCC; dest_write_en = 1'b1;
        #1 chk("rdw_old", 32'(dest_readdata), 32'hBBBB);
        tick();
        dest_write_en = 1'b0;
        #1 chk("rdw_new", 32'(dest_readdata), 32'hCCCC);

        // eng_busy blocks command, then pauses a LOAD of 5 words
        eng_busy = 1'b1;
        cmd_valid = 1'b1; cmd_op = 1'b0; cmd_addr = 14'h0100; cmd_len = 14'd5;
        #1 chk("busy_cmd_ready", 32'(cmd_ready), 0);
        tick();
        eng_busy = 1'b0;
        #1 chk("busy_rel_cmd_ready", 32'(cmd_ready), 1);
        tick();
        cmd_valid = 1'b0;
        ld_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            ld_data = 16'h5000 + 16'(i);
            if (i == 2) begin
                eng_busy = 1'b1;
                #1 chk("busy_ld_ready", 32'(ld_ready), 0);
                tick(); tick();
                chk("busy_ld_ready_hold", 32'(ld_ready), 0);
                chk("busy_no_done", 32'(host_done), 0);
                eng_busy = 1'b0;
                #1 chk("busy_ld_resume", 32'(ld_ready), 1);
            end
            tick();
        end
        ld_valid = 1'b0;
        #1 chk("busy_host_done", 32'(host_done), 1);
        tick();
        for (int i = 0; i < 5; i++) begin
            src2_address = 14'h0100 + 14'(i);
            #1 chk("busy_readback", 32'(src2_readdata), 32'h5000 + 32'(i));
        end

        // Address wrap at top of array
        cmd_valid = 1'b1; cmd_op = 1'b0; cmd_addr = 14'h3FFF; cmd_len = 14'd2;
        tick();
        cmd_valid = 1'b0; ld_valid = 1'b1; ld_data = 16'h7777;
        tick();
        ld_data = 16'h8888;
        tick();
        ld_valid = 1'b0;
        #1 chk("wrap_host_done", 32'(host_done), 1);
        tick();
        src1_address = 14'h3FFF; src2_address = 14'h0000;
        #1 chk("wrap_top", 32'(src1_readdata), 32'h7777);
        chk("wrap_zero", 32'(src2_readdata), 32'h8888);

        // Zero-length command: done pulse, no write
        cmd_valid = 1'b1; cmd_op = 1'b0; cmd_addr = 14'h0010; cmd_len = 14'd0;
        ld_valid = 1'b1; ld_data = 16'hDEAD;
        tick();
        cmd_valid = 1'b0;
        #1 chk("zlen_host_done", 32'(host_done), 1);
        chk("zlen_ld_ready", 32'(ld_ready), 0);
        tick();
        ld_valid = 1'b0;
        chk("zlen_done_clr", 32'(host_done), 0);
        src1_address = 14'h0010;
        #1 chk("zlen_mem", 32'(src1_readdata), 32'h3C00);

        // Reset during UNLOAD with a valid last word pending
        cmd_valid = 1'b1; cmd_op = 1'b1; cmd_addr = 14'h0100; cmd_len = 14'd1; ul_ready = 1'b0;
        tick();
        cmd_valid = 1'b0;
        chk("rstul_valid", 32'(ul_valid), 1);
        chk("rstul_last", 32'(ul_last), 1);
        chk("rstul_data", 32'(ul_data), 32'h5000);
        reset = 1'b1;
        #1 chk("rstul_valid_drop", 32'(ul_valid), 0);
        chk("rstul_last_drop", 32'(ul_last), 0);
        tick();
        reset = 1'b0;
        #1 chk("rstul_cmd_ready", 32'(cmd_ready), 1);
        chk("rstul_no_done", 32'(host_done), 0);
        tick();
        chk("rstul_idle_done", 32'(host_done), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
